// File: rtl/stream_ready_delay.sv
// stream_ready_delay: consumer-side handshake delayer.
// Each beat waits until downstream ready_i has been high for D counted cycles
// before it is exposed and accepted. D is fixed or taken from a 16-bit LFSR.
// This back-pressures producers in simulation and emulation builds.
// The payload passes straight through; the block stores no data.
module stream_ready_delay #(
  parameter bit          StallRandom = 1'b0,
  parameter int unsigned FixedDelay  = 1,
  parameter logic [15:0] LfsrSeed    = 16'hACE1,
  parameter type         payload_t   = logic
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  payload_t    payload_i,
  input  logic        valid_i,
  output logic        ready_o,
  output payload_t    payload_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] stall_cnt_o
);

  assign payload_o = payload_i;

  if (FixedDelay == 0 && !StallRandom) begin : g_pass
    // No delay is possible, so the block is wires only and keeps no state.
    logic unused_ctl;
    assign unused_ctl  = clk_i ^ rst_ni ^ clr_i;
    assign ready_o     = ready_i;
    assign valid_o     = valid_i;
    assign stall_cnt_o = '0;
  end else begin : g_delay
    typedef enum logic [1:0] {
      Closed = 2'd0,
      Count  = 2'd1,
      Open   = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] lfsr_q;
    logic [15:0] stall_q;
    logic [3:0]  delay;
    logic        lfsr_fb;

    // Delay for the beat that is about to be loaded.
    assign delay   = StallRandom ? lfsr_q[3:0] : 4'(FixedDelay);
    // Feedback for x^16+x^14+x^13+x^11+1 with a left shift.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Expose the beat only in Open, or in Closed when the delay is zero.
    // valid_o comes from state and valid_i only, so it does not depend on ready_i.
    always_comb begin
      valid_o = 1'b0;
      ready_o = 1'b0;
      case (state_q)
        Closed: begin
          if (delay == 4'd0) begin
            valid_o = valid_i;
            ready_o = ready_i;
          end
        end
        Open: begin
          valid_o = valid_i;
          ready_o = ready_i;
        end
        default: ;
      endcase
    end

    // Beat FSM. Only ready_i-high cycles count toward the delay.
    // The LFSR advances only when a delay is loaded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= Closed;
        cnt_q   <= '0;
        lfsr_q  <= LfsrSeed;
      end else if (clr_i) begin
        state_q <= Closed;
        cnt_q   <= '0;
        lfsr_q  <= LfsrSeed;
      end else begin
        case (state_q)
          Closed: begin
            if (ready_i) begin
              lfsr_q <= {lfsr_q[14:0], lfsr_fb};
              if (delay == 4'd0) begin
                // With a zero delay, a present beat transfers now and the next beat reloads.
                state_q <= valid_i ? Closed : Open;
              end else if (delay == 4'd1) begin
                state_q <= Open;
              end else begin
                cnt_q   <= delay - 4'd1;
                state_q <= Count;
              end
            end
          end
          Count: begin
            if (ready_i) begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) state_q <= Open;
            end
          end
          Open: begin
            // Once a beat is exposed it is never stalled again, so valid_o cannot retract.
            if (valid_i && ready_i) state_q <= Closed;
          end
          default: state_q <= Closed;
        endcase
      end
    end

    // Saturating count of cycles in which both sides are willing but the beat is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_q <= '0;
      end else if (clr_i) begin
        stall_q <= '0;
      end else if (valid_i && ready_i && !ready_o && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end

    assign stall_cnt_o = stall_q;
  end

endmodule

// File: tb/tb_stream_ready_delay.sv
// Bench for stream_ready_delay.
// Four configurations run against a per-beat behavioural model:
//   u0 fixed 3, u1 pass-through, u2 LFSR-random, u3 fixed 15 (stall saturation).
module tb_stream_ready_delay;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [4];
  logic        clr  [4];
  logic        v_in [4];
  logic        r_in [4];
  logic        v_o  [4];
  logic        r_o  [4];
  logic [7:0]  pl_in[4];
  logic [7:0]  pl_o [4];
  logic [15:0] sc_o [4];

  stream_ready_delay #(.StallRandom(1'b0), .FixedDelay(3), .LfsrSeed(SEED), .payload_t(logic [7:0])) u0 (
    .clk_i(clk), .rst_ni(rstn[0]), .clr_i(clr[0]), .payload_i(pl_in[0]), .valid_i(v_in[0]),
    .ready_o(r_o[0]), .payload_o(pl_o[0]), .valid_o(v_o[0]), .ready_i(r_in[0]), .stall_cnt_o(sc_o[0]));
  stream_ready_delay #(.StallRandom(1'b0), .FixedDelay(0), .LfsrSeed(SEED), .payload_t(logic [7:0])) u1 (
    .clk_i(clk), .rst_ni(rstn[1]), .clr_i(clr[1]), .payload_i(pl_in[1]), .valid_i(v_in[1]),
    .ready_o(r_o[1]), .payload_o(pl_o[1]), .valid_o(v_o[1]), .ready_i(r_in[1]), .stall_cnt_o(sc_o[1]));
  stream_ready_delay #(.StallRandom(1'b1), .FixedDelay(1), .LfsrSeed(SEED), .payload_t(logic [7:0])) u2 (
    .clk_i(clk), .rst_ni(rstn[2]), .clr_i(clr[2]), .payload_i(pl_in[2]), .valid_i(v_in[2]),
    .ready_o(r_o[2]), .payload_o(pl_o[2]), .valid_o(v_o[2]), .ready_i(r_in[2]), .stall_cnt_o(sc_o[2]));
  stream_ready_delay #(.StallRandom(1'b0), .FixedDelay(15), .LfsrSeed(SEED), .payload_t(logic [7:0])) u3 (
    .clk_i(clk), .rst_ni(rstn[3]), .clr_i(clr[3]), .payload_i(pl_in[3]), .valid_i(v_in[3]),
    .ready_o(r_o[3]), .payload_o(pl_o[3]), .valid_o(v_o[3]), .ready_i(r_in[3]), .stall_cnt_o(sc_o[3]));

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;

  // Model state for each beat: the delay it needs, the ready cycles it has seen,
  // the LFSR value for the beat, and the stall count.
  int          need [4];
  int          seen [4];
  logic [15:0] m_lfsr [4];
  logic [15:0] m_stall[4];

  // Snapshot of the DUT outputs taken at the latest negedge.
  logic        s_v [4];
  logic        s_r [4];
  logic [15:0] s_sc[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int beat_delay(input int k, input logic [15:0] s);
    if (k == 2) return int'(s[3:0]);
    case (k)
      0: return 3;
      3: return 15;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset(input int k);
    m_lfsr[k]  = SEED;
    need[k]    = beat_delay(k, SEED);
    seen[k]    = 0;
    m_stall[k] = 16'd0;
  endtask

  // Compare every instance with the model, then advance the model across the next clock edge.
  task automatic model_cmp();
    logic op, e_v, e_r;
    for (int k = 0; k < 4; k++) begin
      if (!rstn[k]) m_reset(k);
      op  = (seen[k] >= need[k]);
      e_v = op & v_in[k];
      e_r = op & r_in[k];
      s_v[k]  = v_o[k];
      s_r[k]  = r_o[k];
      s_sc[k] = sc_o[k];
      chk($sformatf("u%0d_cyc%0d", k, cyc_n),
          32'({v_o[k], r_o[k], pl_o[k], sc_o[k]}),
          32'({e_v, e_r, pl_in[k], m_stall[k]}));
      if (rstn[k]) begin
        if (clr[k]) m_reset(k);
        else begin
          if (v_in[k] && r_in[k] && !e_r && m_stall[k] != 16'hFFFF) m_stall[k] = m_stall[k] + 16'd1;
          if (op) begin
            if (v_in[k] && r_in[k]) begin
              m_lfsr[k] = lfsr_step(m_lfsr[k]);
              need[k]   = beat_delay(k, m_lfsr[k]);
              seen[k]   = 0;
            end
          end else if (r_in[k]) begin
            seen[k] = seen[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_cmp();
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_inst(input int k);
    rstn[k] = 1'b0; clr[k] = 1'b0; v_in[k] = 1'b0; r_in[k] = 1'b0;
    cyc();
    rstn[k] = 1'b1;
  endtask

  logic [15:0] rh, vh, sc_a, sc_b, sc_c;
  int nacc;
  int acc_t[3];

  initial begin
    for (int k = 0; k < 4; k++) begin
      rstn[k] = 1'b0; clr[k] = 1'b0; v_in[k] = 1'b0; r_in[k] = 1'b0; pl_in[k] = 8'h00;
      m_reset(k);
    end
    v_in[0] = 1'b1; r_in[0] = 1'b1;
    v_in[3] = 1'b1; r_in[3] = 1'b1;

    // These checks pin the model's LFSR sequence to hand-computed values.
    chk("model_step1", 32'(lfsr_step(16'hACE1)), 32'h59C3);
    chk("model_step2", 32'(lfsr_step(16'h59C3)), 32'hB387);

    // Reset state, with both handshake inputs held high.
    cyc();
    chk("rst_u0", 32'({s_v[0], s_r[0], s_sc[0]}), 32'h0);
    cyc();
    v_in[0] = 1'b0; r_in[0] = 1'b0;
    for (int k = 0; k < 4; k++) rstn[k] = 1'b1;

    // Test 1: fixed 3, ready held high. Handshakes land at t3 and t7; stall count is 3.
    v_in[0] = 1'b1; r_in[0] = 1'b1; pl_in[0] = 8'h3C;
    rh = '0; vh = '0; sc_a = '0;
    for (int t = 0; t < 8; t++) begin
      cyc();
      rh[t] = s_r[0]; vh[t] = s_v[0];
      if (t == 4) sc_a = s_sc[0];
    end
    chk("t1_ready", 32'(rh), 32'h88);
    chk("t1_valid", 32'(vh), 32'h88);
    chk("t1_stall", 32'(sc_a), 32'd3);

    // Test 2: ready drops for 2 cycles during Count, so acceptance moves from t3 to t5.
    rst_inst(0);
    v_in[0] = 1'b1;
    rh = '0;
    for (int t = 0; t < 6; t++) begin
      r_in[0] = !(t == 1 || t == 2);
      cyc();
      rh[t] = s_r[0];
    end
    chk("t2_ready", 32'(rh), 32'h20);

    // Test 5: beat exposed in Open while ready toggles 1-0-0-1. Valid holds and one transfer occurs.
    rst_inst(0);
    pl_in[0] = 8'h5A;
    rh = '0; vh = '0; sc_a = 16'hDEAD;
    for (int t = 0; t < 7; t++) begin
      v_in[0] = (t >= 3 && t <= 5);
      r_in[0] = (t < 3 || t == 5);
      cyc();
      rh[t] = s_r[0]; vh[t] = s_v[0];
      if (t == 6) sc_a = s_sc[0];
    end
    chk("t5_valid", 32'(vh), 32'h38);
    chk("t5_ready", 32'(rh), 32'h20);
    chk("t5_stall", 32'(sc_a), 32'd0);

    // Test 6: clr in Count at t1, then async reset while in Open at t9.
    rst_inst(0);
    rh = '0; vh = '0;
    for (int t = 0; t < 14; t++) begin
      clr[0]  = (t == 1);
      rstn[0] = (t != 9);
      v_in[0] = !(t >= 6 && t <= 8);
      r_in[0] = 1'b1;
      cyc();
      rh[t] = s_r[0]; vh[t] = s_v[0];
      if (t == 2)  sc_a = s_sc[0];
      if (t == 5)  sc_b = s_sc[0];
      if (t == 10) sc_c = s_sc[0];
    end
    clr[0] = 1'b0; rstn[0] = 1'b1; v_in[0] = 1'b0; r_in[0] = 1'b0;
    chk("t6_ready", 32'(rh), 32'h2020);
    chk("t6_valid", 32'(vh), 32'h2020);
    chk("t6_clr_stall", 32'(sc_a), 32'd0);
    chk("t6_mid_stall", 32'(sc_b), 32'd3);
    chk("t6_rst_stall", 32'(sc_c), 32'd0);

    // Test 3: pass-through under random traffic.
    for (int t = 0; t < 100; t++) begin
      v_in[1]  = 1'($urandom_range(0, 1));
      r_in[1]  = 1'($urandom_range(0, 1));
      pl_in[1] = 8'($urandom);
      cyc();
    end
    v_in[1] = 1'b0; r_in[1] = 1'b0;
    chk("t3_stall", 32'(s_sc[1]), 32'd0);

    // Test 4: random delays with 1000 back-to-back beats. The first gaps are D=1,3,7.
    rst_inst(2);
    v_in[2] = 1'b1; r_in[2] = 1'b1; pl_in[2] = 8'h00;
    nacc = 0;
    for (int i = 0; i < 3; i++) acc_t[i] = -1;
    for (int t = 0; t < 20000 && nacc < 1000; t++) begin
      cyc();
      if (s_r[2]) begin
        if (nacc < 3) acc_t[nacc] = t;
        nacc++;
        pl_in[2] = pl_in[2] + 8'd1;
      end
    end
    v_in[2] = 1'b0; r_in[2] = 1'b0;
    chk("t4_beats", 32'(nacc), 32'd1000);
    chk("t4_acc0", 32'(acc_t[0]), 32'd1);
    chk("t4_acc1", 32'(acc_t[1]), 32'd5);
    chk("t4_acc2", 32'(acc_t[2]), 32'd13);

    // After reset the LFSR restarts from the seed, so the gaps are 1 then 3 again.
    rst_inst(2);
    v_in[2] = 1'b1; r_in[2] = 1'b1;
    rh = '0;
    for (int t = 0; t < 6; t++) begin
      cyc();
      rh[t] = s_r[2];
    end
    v_in[2] = 1'b0; r_in[2] = 1'b0;
    chk("t4_reseed", 32'(rh), 32'h22);

    // u3 has run since reset release, stalling 15 of every 16 cycles. It must saturate.
    while (cyc_n < 70200) cyc();
    chk("sat_stall", 32'(s_sc[3]), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
